// File: rtl/axi4_sram_slave.sv
// AXI4 slave to 1-cycle SRAM: writes land the cycle after AW accept, first R beat 2 cycles after AR accept.
// Backpressure: 2-entry read buffer throttles SRAM issue; one outstanding transaction, B/R held until ready.
module axi4_sram_slave #(
  parameter logic [63:0] ADDR_BASE      = 64'h8000_0000,
  parameter int          MEM_WORDS_LOG2 = 16,
  parameter int          ID_W           = 4
) (
  input  logic                      CLK,
  input  logic                      RST_N,

  input  logic                      s_awvalid,
  input  logic [ID_W-1:0]           s_awid,
  input  logic [63:0]               s_awaddr,
  input  logic [7:0]                s_awlen,
  input  logic [2:0]                s_awsize,
  input  logic [1:0]                s_awburst,
  input  logic                      s_awlock,
  input  logic [3:0]                s_awcache,
  input  logic [2:0]                s_awprot,
  input  logic [3:0]                s_awqos,
  input  logic [3:0]                s_awregion,
  output logic                      s_awready,

  input  logic                      s_wvalid,
  input  logic [63:0]               s_wdata,
  input  logic [7:0]                s_wstrb,
  input  logic                      s_wlast,
  output logic                      s_wready,

  output logic                      s_bvalid,
  output logic [ID_W-1:0]           s_bid,
  output logic [1:0]                s_bresp,
  input  logic                      s_bready,

  input  logic                      s_arvalid,
  input  logic [ID_W-1:0]           s_arid,
  input  logic [63:0]               s_araddr,
  input  logic [7:0]                s_arlen,
  input  logic [2:0]                s_arsize,
  input  logic [1:0]                s_arburst,
  input  logic                      s_arlock,
  input  logic [3:0]                s_arcache,
  input  logic [2:0]                s_arprot,
  input  logic [3:0]                s_arqos,
  input  logic [3:0]                s_arregion,
  output logic                      s_arready,

  output logic                      s_rvalid,
  output logic [ID_W-1:0]           s_rid,
  output logic [63:0]               s_rdata,
  output logic [1:0]                s_rresp,
  output logic                      s_rlast,
  input  logic                      s_rready,

  output logic                      mem_en,
  output logic [7:0]                mem_we,
  output logic [MEM_WORDS_LOG2-1:0] mem_addr,
  output logic [63:0]               mem_wdata,
  input  logic [63:0]               mem_rdata
);

  typedef enum logic [1:0] {IDLE, WR_DATA, WR_RESP, RD} state_t;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  RESP_DECERR = 2'b11;
  localparam logic [1:0]  BURST_INCR  = 2'b01;
  localparam logic [64:0] ADDR_LIMIT  = {1'b0, ADDR_BASE} + (65'd8 << MEM_WORDS_LOG2);

  state_t          state;
  logic            last_grant_was_read;
  logic [ID_W-1:0] id_q;
  logic [63:0]     addr_q;
  logic [7:0]      len_q;
  logic [2:0]      size_q;
  logic [1:0]      burst_q;
  logic            unsup_q;
  logic [8:0]      beat_cnt;
  logic            dec_err;
  logic [1:0]      bresp_q;

  // single-stage read pipeline tracking the beat whose SRAM data is on mem_rdata
  logic            p_vld;
  logic [1:0]      p_resp;
  logic            p_last;
  logic [63:0]     p_data;

  logic [63:0]     fifo_data [2];
  logic [1:0]      fifo_resp [2];
  logic            fifo_last [2];
  logic            fifo_wp;
  logic            fifo_rp;
  logic [1:0]      fifo_cnt;

  logic            pick_w;
  logic            w_hs;
  logic            w_access;
  logic            rd_issue;
  logic            rd_access;
  logic            in_range;
  logic [63:0]     addr_off;
  logic [63:0]     next_addr;
  logic [1:0]      issue_resp;
  logic            issue_last;
  logic            r_hs;
  logic            push;
  logic            pop;
  logic            w_last_dec;
  logic            w_last_slv;

  assign pick_w    = s_awvalid & (~s_arvalid | last_grant_was_read);
  assign s_awready = (state == IDLE) & pick_w;
  assign s_arready = (state == IDLE) & s_arvalid & ~pick_w;
  assign s_wready  = (state == WR_DATA);
  assign s_bvalid  = (state == WR_RESP);
  assign s_bid     = id_q;
  assign s_bresp   = bresp_q;
  assign s_rid     = id_q;

  assign addr_off  = addr_q - ADDR_BASE;
  assign in_range  = (addr_q >= ADDR_BASE) & ({1'b0, addr_q} < ADDR_LIMIT);
  assign next_addr = (burst_q == BURST_INCR) ? addr_q + (64'd1 << size_q) : addr_q;

  assign w_hs      = (state == WR_DATA) & s_wvalid;
  assign w_access  = w_hs & ~unsup_q & in_range;
  assign rd_issue  = (state == RD) & (beat_cnt <= {1'b0, len_q})
                   & (({1'b0, fifo_cnt} + {2'b00, p_vld}) < 3'd2);
  assign rd_access = rd_issue & ~unsup_q & in_range;

  assign mem_en    = w_access | rd_access;
  assign mem_we    = w_access ? s_wstrb : 8'h00;
  assign mem_addr  = addr_off[MEM_WORDS_LOG2+2:3];
  assign mem_wdata = s_wdata;

  assign issue_resp = unsup_q ? RESP_SLVERR : (in_range ? RESP_OKAY : RESP_DECERR);
  assign issue_last = (beat_cnt == {1'b0, len_q});

  assign w_last_dec = dec_err | (~unsup_q & ~in_range);
  assign w_last_slv = unsup_q | (beat_cnt != {1'b0, len_q});

  assign p_data = (p_resp == RESP_OKAY) ? mem_rdata : 64'd0;

  // R head comes from the buffer when it holds data, otherwise straight from the pipeline stage
  always_comb begin
    s_rvalid = 1'b0;
    s_rdata  = 64'd0;
    s_rresp  = RESP_OKAY;
    s_rlast  = 1'b0;
    if (fifo_cnt != 2'd0) begin
      s_rvalid = 1'b1;
      s_rdata  = fifo_data[fifo_rp];
      s_rresp  = fifo_resp[fifo_rp];
      s_rlast  = fifo_last[fifo_rp];
    end else if (p_vld) begin
      s_rvalid = 1'b1;
      s_rdata  = p_data;
      s_rresp  = p_resp;
      s_rlast  = p_last;
    end
  end

  assign r_hs = s_rvalid & s_rready;
  assign push = p_vld & ~((fifo_cnt == 2'd0) & s_rready);
  assign pop  = r_hs & (fifo_cnt != 2'd0);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state               <= IDLE;
      last_grant_was_read <= 1'b1;
      id_q                <= '0;
      addr_q              <= 64'd0;
      len_q               <= 8'd0;
      size_q              <= 3'd0;
      burst_q             <= 2'd0;
      unsup_q             <= 1'b0;
      beat_cnt            <= 9'd0;
      dec_err             <= 1'b0;
      bresp_q             <= RESP_OKAY;
      p_vld               <= 1'b0;
      p_resp              <= RESP_OKAY;
      p_last              <= 1'b0;
      fifo_wp             <= 1'b0;
      fifo_rp             <= 1'b0;
      fifo_cnt            <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (s_awready) begin
            state               <= WR_DATA;
            last_grant_was_read <= 1'b0;
            id_q                <= s_awid;
            addr_q              <= s_awaddr;
            len_q               <= s_awlen;
            size_q              <= s_awsize;
            burst_q             <= s_awburst;
            unsup_q             <= (s_awsize > 3'd3) | s_awburst[1];
            beat_cnt            <= 9'd0;
            dec_err             <= 1'b0;
          end else if (s_arready) begin
            state               <= RD;
            last_grant_was_read <= 1'b1;
            id_q                <= s_arid;
            addr_q              <= s_araddr;
            len_q               <= s_arlen;
            size_q              <= s_arsize;
            burst_q             <= s_arburst;
            unsup_q             <= (s_arsize > 3'd3) | s_arburst[1];
            beat_cnt            <= 9'd0;
          end
        end
        WR_DATA: begin
          if (w_hs) begin
            addr_q <= next_addr;
            if (beat_cnt != 9'h1FF) beat_cnt <= beat_cnt + 9'd1;
            if (~unsup_q & ~in_range) dec_err <= 1'b1;
            if (s_wlast) begin
              state   <= WR_RESP;
              bresp_q <= w_last_dec ? RESP_DECERR : (w_last_slv ? RESP_SLVERR : RESP_OKAY);
            end
          end
        end
        WR_RESP: begin
          if (s_bready) state <= IDLE;
        end
        RD: begin
          if (rd_issue) begin
            addr_q   <= next_addr;
            beat_cnt <= beat_cnt + 9'd1;
          end
          if (r_hs & s_rlast) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      p_vld  <= rd_issue;
      p_resp <= issue_resp;
      p_last <= issue_last;

      if (push) begin
        fifo_data[fifo_wp] <= p_data;
        fifo_resp[fifo_wp] <= p_resp;
        fifo_last[fifo_wp] <= p_last;
        fifo_wp            <= ~fifo_wp;
      end
      if (pop) fifo_rp <= ~fifo_rp;
      if (push & ~pop)      fifo_cnt <= fifo_cnt + 2'd1;
      else if (pop & ~push) fifo_cnt <= fifo_cnt - 2'd1;
    end
  end

  logic unused_sig;
  assign unused_sig = ^{s_awlock, s_awcache, s_awprot, s_awqos, s_awregion,
                        s_arlock, s_arcache, s_arprot, s_arqos, s_arregion,
                        addr_off[63:MEM_WORDS_LOG2+3], addr_off[2:0]};

endmodule

// File: tb/tb_axi4_sram_slave.sv
// Directed bench for axi4_sram_slave with a behavioural one-cycle SRAM behind it.
module tb_axi4_sram_slave;

  localparam int ID_W = 4;
  localparam int MWL  = 16;

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  logic            s_awvalid, s_awready, s_awlock;
  logic [ID_W-1:0] s_awid;
  logic [63:0]     s_awaddr;
  logic [7:0]      s_awlen;
  logic [2:0]      s_awsize, s_awprot;
  logic [1:0]      s_awburst;
  logic [3:0]      s_awcache, s_awqos, s_awregion;
  logic            s_wvalid, s_wlast, s_wready;
  logic [63:0]     s_wdata;
  logic [7:0]      s_wstrb;
  logic            s_bvalid, s_bready;
  logic [ID_W-1:0] s_bid;
  logic [1:0]      s_bresp;
  logic            s_arvalid, s_arready, s_arlock;
  logic [ID_W-1:0] s_arid;
  logic [63:0]     s_araddr;
  logic [7:0]      s_arlen;
  logic [2:0]      s_arsize, s_arprot;
  logic [1:0]      s_arburst;
  logic [3:0]      s_arcache, s_arqos, s_arregion;
  logic            s_rvalid, s_rlast, s_rready;
  logic [ID_W-1:0] s_rid;
  logic [63:0]     s_rdata;
  logic [1:0]      s_rresp;
  logic            mem_en;
  logic [7:0]      mem_we;
  logic [MWL-1:0]  mem_addr;
  logic [63:0]     mem_wdata, mem_rdata;

  axi4_sram_slave #(.ADDR_BASE(64'h8000_0000), .MEM_WORDS_LOG2(MWL), .ID_W(ID_W)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .s_awvalid(s_awvalid), .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
    .s_awsize(s_awsize), .s_awburst(s_awburst), .s_awlock(s_awlock), .s_awcache(s_awcache),
    .s_awprot(s_awprot), .s_awqos(s_awqos), .s_awregion(s_awregion), .s_awready(s_awready),
    .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bid(s_bid), .s_bresp(s_bresp), .s_bready(s_bready),
    .s_arvalid(s_arvalid), .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arlock(s_arlock), .s_arcache(s_arcache),
    .s_arprot(s_arprot), .s_arqos(s_arqos), .s_arregion(s_arregion), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rready(s_rready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // behavioural SRAM: byte-enabled write, read data one cycle after mem_en
  logic [63:0] sram [0:(1<<MWL)-1];
  int mem_en_cnt = 0;
  always @(posedge CLK) begin
    if (mem_en) begin
      mem_en_cnt <= mem_en_cnt + 1;
      if (mem_we == 8'h00) mem_rdata <= sram[mem_addr];
      else for (int b = 0; b < 8; b++)
        if (mem_we[b]) sram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic sel_sig(input int which);
    case (which)
      0:       return s_awready;
      1:       return s_wready;
      2:       return s_bvalid;
      default: return s_arready;
    endcase
  endfunction

  // returns at the negedge where the selected signal is high (handshake at the next posedge)
  task automatic wait_hi(input int which, input string tag);
    int t = 0;
    @(negedge CLK);
    while (!sel_sig(which) && t < 50) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 50) check({tag, "_timeout"}, {63'd0, sel_sig(which)}, 64'd1);
  endtask

  task automatic axi_write(input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id, input logic [63:0] data,
                           input logic [7:0] strb, output logic [1:0] resp, output logic [3:0] bid);
    @(posedge CLK); #1;
    s_awvalid = 1'b1; s_awaddr = addr; s_awlen = len; s_awsize = size; s_awburst = burst; s_awid = id;
    wait_hi(0, "aw");
    @(posedge CLK); #1;
    s_awvalid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      s_wvalid = 1'b1; s_wdata = data + 64'(b); s_wstrb = strb; s_wlast = (b == int'(len));
      wait_hi(1, "w");
      @(posedge CLK); #1;
    end
    s_wvalid = 1'b0; s_wlast = 1'b0;
    s_bready = 1'b1;
    wait_hi(2, "b");
    resp = s_bresp; bid = s_bid;
    @(posedge CLK); #1;
    s_bready = 1'b0;
  endtask

  logic [63:0] rd_data [$];
  logic [1:0]  rd_resp [$];
  logic        rd_last [$];
  int          rd_cyc  [$];
  logic [3:0]  rd_rid;

  task automatic axi_read(input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] id, input logic [15:0] rpat);
    int k = 1;
    logic done = 1'b0;
    logic stalled = 1'b0;
    logic [63:0] st_data = 64'd0;
    logic [1:0]  st_resp = 2'd0;
    logic        st_last = 1'b0;
    rd_data.delete(); rd_resp.delete(); rd_last.delete(); rd_cyc.delete();
    @(posedge CLK); #1;
    s_arvalid = 1'b1; s_araddr = addr; s_arlen = len; s_arsize = size; s_arburst = burst; s_arid = id;
    wait_hi(3, "ar");
    @(posedge CLK); #1;
    s_arvalid = 1'b0;
    while (!done && k < 100) begin
      s_rready = rpat[k % 16];
      @(negedge CLK);
      if (stalled) begin
        check("r_stall_vld",  {63'd0, s_rvalid}, 64'd1);
        check("r_stall_data", s_rdata, st_data);
        check("r_stall_resp", {62'd0, s_rresp}, {62'd0, st_resp});
        check("r_stall_last", {63'd0, s_rlast}, {63'd0, st_last});
        stalled = 1'b0;
      end
      if (s_rvalid && s_rready) begin
        rd_data.push_back(s_rdata); rd_resp.push_back(s_rresp);
        rd_last.push_back(s_rlast); rd_cyc.push_back(k);
        rd_rid = s_rid;
        if (s_rlast) done = 1'b1;
      end else if (s_rvalid) begin
        stalled = 1'b1; st_data = s_rdata; st_resp = s_rresp; st_last = s_rlast;
      end
      @(posedge CLK); #1;
      k++;
    end
    s_rready = 1'b0;
    if (!done) check("r_timeout", {63'd0, done}, 64'd1);
  endtask

  logic [1:0] resp;
  logic [3:0] bid;
  int         e0;
  logic [3:0] grants;
  int         ng;

  initial begin
    RST_N = 1'b0;
    {s_awvalid, s_awlock, s_awid, s_awaddr, s_awlen, s_awsize, s_awprot, s_awburst} = '0;
    {s_awcache, s_awqos, s_awregion} = '0;
    {s_wvalid, s_wlast, s_wdata, s_wstrb, s_bready} = '0;
    {s_arvalid, s_arlock, s_arid, s_araddr, s_arlen, s_arsize, s_arprot, s_arburst} = '0;
    {s_arcache, s_arqos, s_arregion, s_rready} = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_awready", {63'd0, s_awready}, 64'd0);
    check("rst_arready", {63'd0, s_arready}, 64'd0);
    check("rst_wready",  {63'd0, s_wready},  64'd0);
    check("rst_bvalid",  {63'd0, s_bvalid},  64'd0);
    check("rst_rvalid",  {63'd0, s_rvalid},  64'd0);
    check("rst_mem_en",  {63'd0, mem_en},    64'd0);
    check("rst_mem_we",  {56'd0, mem_we},    64'd0);
    check("rst_bresp",   {62'd0, s_bresp},   64'd0);
    check("rst_rresp",   {62'd0, s_rresp},   64'd0);
    check("rst_rdata",   s_rdata,            64'd0);
    @(posedge CLK); #1;
    RST_N = 1'b1;

    // single beat write and readback
    e0 = mem_en_cnt;
    axi_write(64'h8000_0000, 8'd0, 3'd3, 2'b01, 4'h5, 64'h1122_3344_5566_7788, 8'hFF, resp, bid);
    check("w1_bresp", {62'd0, resp}, 64'd0);
    check("w1_bid",   {60'd0, bid},  64'h5);
    check("w1_mem_en", 64'(mem_en_cnt - e0), 64'd1);
    axi_read(64'h8000_0000, 8'd0, 3'd3, 2'b01, 4'h6, 16'hFFFF);
    check("r1_beats", 64'(rd_data.size()), 64'd1);
    if (rd_data.size() == 1) begin
      check("r1_data", rd_data[0], 64'h1122_3344_5566_7788);
      check("r1_resp", {62'd0, rd_resp[0]}, 64'd0);
      check("r1_last", {63'd0, rd_last[0]}, 64'd1);
      check("r1_first_cycle", 64'(rd_cyc[0]), 64'd2);
      check("r1_rid", {60'd0, rd_rid}, 64'h6);
    end

    // fill words 2..5, then INCR read with rready high and with rready toggling
    e0 = mem_en_cnt;
    axi_write(64'h8000_0010, 8'd3, 3'd3, 2'b01, 4'h1, 64'hC0DE_0000_0000_0000, 8'hFF, resp, bid);
    check("w4_bresp", {62'd0, resp}, 64'd0);
    check("w4_mem_en", 64'(mem_en_cnt - e0), 64'd4);
    axi_read(64'h8000_0010, 8'd3, 3'd3, 2'b01, 4'h2, 16'hFFFF);
    check("r4_beats", 64'(rd_data.size()), 64'd4);
    for (int i = 0; i < 4 && i < rd_data.size(); i++) begin
      check("r4_data", rd_data[i], 64'hC0DE_0000_0000_0000 + 64'(i));
      check("r4_last", {63'd0, rd_last[i]}, {63'd0, (i == 3)});
      check("r4_cycle", 64'(rd_cyc[i]), 64'(2 + i));
    end
    axi_read(64'h8000_0010, 8'd3, 3'd3, 2'b01, 4'h3, 16'h9999);
    check("r4s_beats", 64'(rd_data.size()), 64'd4);
    for (int i = 0; i < 4 && i < rd_data.size(); i++) begin
      check("r4s_data", rd_data[i], 64'hC0DE_0000_0000_0000 + 64'(i));
      check("r4s_last", {63'd0, rd_last[i]}, {63'd0, (i == 3)});
    end

    // out of range write and read
    e0 = mem_en_cnt;
    axi_write(64'h0000_1000, 8'd0, 3'd3, 2'b01, 4'h7, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, resp, bid);
    check("oor_w_bresp", {62'd0, resp}, 64'h3);
    check("oor_w_mem_en", 64'(mem_en_cnt - e0), 64'd0);
    axi_read(64'h0000_1000, 8'd0, 3'd3, 2'b01, 4'h7, 16'hFFFF);
    check("oor_r_beats", 64'(rd_data.size()), 64'd1);
    if (rd_data.size() == 1) begin
      check("oor_r_data", rd_data[0], 64'd0);
      check("oor_r_resp", {62'd0, rd_resp[0]}, 64'h3);
      check("oor_r_last", {63'd0, rd_last[0]}, 64'd1);
    end

    // narrow write with partial strobe
    axi_write(64'h8000_0040, 8'd0, 3'd3, 2'b01, 4'h0, 64'hFFFF_FFFF_0000_0000, 8'hFF, resp, bid);
    axi_write(64'h8000_0040, 8'd0, 3'd2, 2'b01, 4'h0, 64'h1234_5678_9ABC_DEF0, 8'h0F, resp, bid);
    check("strb_bresp", {62'd0, resp}, 64'd0);
    axi_read(64'h8000_0040, 8'd0, 3'd3, 2'b01, 4'h0, 16'hFFFF);
    if (rd_data.size() == 1) check("strb_data", rd_data[0], 64'hFFFF_FFFF_9ABC_DEF0);
    else check("strb_beats", 64'(rd_data.size()), 64'd1);

    // WRAP burst is unsupported: two SLVERR beats, no SRAM access
    e0 = mem_en_cnt;
    axi_read(64'h8000_0000, 8'd1, 3'd3, 2'b10, 4'h9, 16'hFFFF);
    check("wrap_beats", 64'(rd_data.size()), 64'd2);
    check("wrap_mem_en", 64'(mem_en_cnt - e0), 64'd0);
    for (int i = 0; i < 2 && i < rd_data.size(); i++) begin
      check("wrap_resp", {62'd0, rd_resp[i]}, 64'h2);
      check("wrap_data", rd_data[i], 64'd0);
      check("wrap_last", {63'd0, rd_last[i]}, {63'd0, (i == 1)});
    end

    // reset in the middle of a stalled read burst
    @(posedge CLK); #1;
    s_arvalid = 1'b1; s_araddr = 64'h8000_0010; s_arlen = 8'd3; s_arsize = 3'd3; s_arburst = 2'b01;
    wait_hi(3, "ar_rst");
    @(posedge CLK); #1;
    s_arvalid = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("midrst_pre_rvalid", {63'd0, s_rvalid}, 64'd1);
    @(posedge CLK); #1;
    RST_N = 1'b0;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(negedge CLK);
    check("midrst_rvalid", {63'd0, s_rvalid}, 64'd0);
    check("midrst_rdata",  s_rdata, 64'd0);
    check("midrst_mem_en", {63'd0, mem_en}, 64'd0);

    // simultaneous AW and AR: grants alternate starting with write
    @(posedge CLK); #1;
    s_awaddr = 64'h8000_0100; s_awlen = 8'd0; s_awsize = 3'd3; s_awburst = 2'b01; s_awid = 4'hA;
    s_araddr = 64'h8000_0108; s_arlen = 8'd0; s_arsize = 3'd3; s_arburst = 2'b01; s_arid = 4'hB;
    s_wvalid = 1'b1; s_wlast = 1'b1; s_wdata = 64'h55; s_wstrb = 8'hFF;
    s_bready = 1'b1; s_rready = 1'b1;
    s_awvalid = 1'b1; s_arvalid = 1'b1;
    grants = 4'd0; ng = 0;
    for (int t = 0; t < 100 && ng < 4; t++) begin
      @(negedge CLK);
      if (s_awvalid && s_awready) begin grants[ng] = 1'b1; ng++; end
      else if (s_arvalid && s_arready) begin grants[ng] = 1'b0; ng++; end
      @(posedge CLK); #1;
      if (ng == 4) begin s_awvalid = 1'b0; s_arvalid = 1'b0; end
    end
    s_awvalid = 1'b0; s_arvalid = 1'b0;
    repeat (6) @(posedge CLK);
    #1;
    s_wvalid = 1'b0; s_wlast = 1'b0; s_bready = 1'b0; s_rready = 1'b0;
    check("arb_count", 64'(ng), 64'd4);
    check("arb_order", {60'd0, grants}, 64'b0101);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
